// File: rtl/compass_pkg.sv
// Shared encodings and defaults for the compass acquisition path.
// Pure definitions: no logic, no latency, no flow control.
package compass_pkg;

    localparam int unsigned DEF_CLK_HZ    = 100_000_000;
    localparam int unsigned DEF_SAMPLE_HZ = 100;
    localparam int unsigned MAG_GAP_CYC   = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ACL_REQ  = 3'd1;
    localparam logic [2:0] ST_ACL_WAIT = 3'd2;
    localparam logic [2:0] ST_MAG_REQ  = 3'd3;
    localparam logic [2:0] ST_MAG_WAIT = 3'd4;
    localparam logic [2:0] ST_MAG_GAP  = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_ACL_REQ  = ST_ACL_REQ,
        S_ACL_WAIT = ST_ACL_WAIT,
        S_MAG_REQ  = ST_MAG_REQ,
        S_MAG_WAIT = ST_MAG_WAIT,
        S_MAG_GAP  = ST_MAG_GAP,
        S_DONE     = ST_DONE
    } sched_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sensor_poll_scheduler_if.sv
// Start/done handshake between the poll scheduler (master) and the SPI/I2C engines (slave).
// Single-cycle pulses both ways; mag_nack qualifies mag_done.
interface sensor_poll_scheduler_if;
    logic acl_start;
    logic acl_done;
    logic mag_start;
    logic mag_done;
    logic mag_nack;

    modport master (
        output acl_start,
        output mag_start,
        input  acl_done,
        input  mag_done,
        input  mag_nack
    );

    modport slave (
        input  acl_start,
        input  mag_start,
        output acl_done,
        output mag_done,
        output mag_nack
    );
endinterface

// File: rtl/poll_tick_gen.sv
// Free-running 0..P-1 period counter; tick_o is high for the single cycle the count equals P-1.
// No flow control: the tick is never held back.
module poll_tick_gen #(
    parameter int unsigned P = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int unsigned CW = $clog2(P);
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sensor_poll_scheduler.sv
// Per tick: one accelerometer read, then a magnetometer read with NACK retries; sample_valid pulses 1 cycle after the ACK.
// Ticks arriving while busy are dropped and counted. SCHED_WATCHDOG_EN adds per-transaction timeouts.
module sensor_poll_scheduler
    import compass_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned SAMPLE_HZ   = DEF_SAMPLE_HZ,
    parameter int unsigned TIMEOUT_CYC = 200_000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    sensor_poll_scheduler_if.master  eng,
    output logic                     sample_valid,
    output logic                     mag_error,
    output logic                     acl_fault,
    output logic [7:0]               overrun_cnt,
    output logic                     busy
);
    localparam int unsigned P  = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW = $clog2(MAG_GAP_CYC);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0] GAP_LAST  = GW'(MAG_GAP_CYC - 1);

    if (P < 16 || TIMEOUT_CYC < 2) begin : g_cfg_err
        $error("sensor_poll_scheduler: tick period below 16 cycles or timeout below 2");
    end

    sched_state_e  state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    ovr_q, ovr_d;
    logic          mag_err_q, mag_err_d;
    logic          mag_fail;
    logic          tick;

    poll_tick_gen #(.P(P)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

`ifdef SCHED_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           wd_exp;
    logic           acl_flt_q, acl_flt_d;

    // Counter sits at 0 during a REQ cycle and reads k on the k-th cycle after the start pulse.
    assign wd_exp = (wd_q == WD_LAST);
    assign wd_d   = (state_d == S_ACL_WAIT || state_d == S_MAG_WAIT) ? wd_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            acl_flt_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            acl_flt_q <= acl_flt_d;
        end
    end

    assign acl_fault = acl_flt_q;
`else
    assign acl_fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        mag_err_d = mag_err_q;
        mag_fail  = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        acl_flt_d = acl_flt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tick && enable) state_d = S_ACL_REQ;
            end
            S_ACL_REQ: state_d = S_ACL_WAIT;
            S_ACL_WAIT: begin
                if (eng.acl_done) begin
                    state_d = S_MAG_REQ;
                    retry_d = '0;
`ifdef SCHED_WATCHDOG_EN
                    acl_flt_d = 1'b0;
                end else if (wd_exp) begin
                    state_d   = S_IDLE;
                    acl_flt_d = 1'b1;
`endif
                end
            end
            S_MAG_REQ: state_d = S_MAG_WAIT;
            S_MAG_WAIT: begin
                if (eng.mag_done) begin
                    if (!eng.mag_nack) begin
                        state_d   = S_DONE;
                        mag_err_d = 1'b0;
                    end else begin
                        mag_fail = 1'b1;
                    end
`ifdef SCHED_WATCHDOG_EN
                end else if (wd_exp) begin
                    mag_fail = 1'b1;
`endif
                end
                if (mag_fail) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_MAG_GAP;
                    end else begin
                        mag_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_MAG_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_MAG_REQ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ticks are never queued: any tick outside IDLE only bumps the overrun count.
    assign ovr_d = (tick && state_q != S_IDLE) ? sat_inc8(ovr_q) : ovr_q;
    assign gap_d = (state_q == S_MAG_GAP) ? gap_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            retry_q   <= '0;
            gap_q     <= '0;
            ovr_q     <= '0;
            mag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            gap_q     <= gap_d;
            ovr_q     <= ovr_d;
            mag_err_q <= mag_err_d;
        end
    end

    assign eng.acl_start = (state_q == S_ACL_REQ);
    assign eng.mag_start = (state_q == S_MAG_REQ);
    assign sample_valid  = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign mag_error     = mag_err_q;
    assign overrun_cnt   = ovr_q;
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench: P=100, timeout 50, two retries; engine models answer after programmable latencies.
// Cycle 0 is the first cycle after the last reset edge, so the first tick lands in cycle 99.
module tb_sensor_poll_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       sample_valid, mag_error, acl_fault, busy;
    logic [7:0] overrun_cnt;

    sensor_poll_scheduler_if eng ();

    sensor_poll_scheduler #(
        .CLK_HZ(1000), .SAMPLE_HZ(10), .TIMEOUT_CYC(50), .MAX_RETRY(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .eng          (eng.master),
        .sample_valid (sample_valid),
        .mag_error    (mag_error),
        .acl_fault    (acl_fault),
        .overrun_cnt  (overrun_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    int acl_q[$];
    int mag_q[$];
    int sv_q[$];
    int overlap = 0;
    always @(negedge clk) begin
        if (reset) begin
            acl_q.delete();
            mag_q.delete();
            sv_q.delete();
        end else begin
            if (eng.acl_start) acl_q.push_back(cyc);
            if (eng.mag_start) mag_q.push_back(cyc);
            if (sample_valid)  sv_q.push_back(cyc);
            if (eng.acl_start && eng.mag_start) overlap++;
        end
    end

    int acl_lat = 5;
    int mag_lat = 7;
    int nack_left = 0;

    initial begin
        eng.acl_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng.acl_start && acl_lat > 0) begin
                repeat (acl_lat) @(negedge clk);
                eng.acl_done = 1'b1;
                @(negedge clk);
                eng.acl_done = 1'b0;
            end
        end
    end

    initial begin
        eng.mag_done = 1'b0;
        eng.mag_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (eng.mag_start && mag_lat > 0) begin
                repeat (mag_lat) @(negedge clk);
                eng.mag_done = 1'b1;
                eng.mag_nack = (nack_left > 0);
                if (nack_left > 0) nack_left--;
                @(negedge clk);
                eng.mag_done = 1'b0;
                eng.mag_nack = 1'b0;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_outputs", {24'd0, eng.acl_start, eng.mag_start, sample_valid,
                            mag_error, acl_fault, busy, 2'b00}, 32'd0);
        chk("rst_overrun", {24'd0, overrun_cnt}, 32'd0);

        // Nominal cycles
        enable  = 1'b1;
        acl_lat = 5;
        mag_lat = 7;
        do_reset();
        wait_cyc(99);
        chk("idle_before_tick", {31'd0, busy}, 32'd0);
        wait_cyc(101);
        chk("busy_in_cycle", {31'd0, busy}, 32'd1);
        wait_cyc(115);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        wait_cyc(320);
        chk("nom_acl0", qat(acl_q, 0), 100);
        chk("nom_mag0", qat(mag_q, 0), 106);
        chk("nom_sv0",  qat(sv_q, 0), 114);
        chk("nom_acl1", qat(acl_q, 1), 200);
        chk("nom_sv2",  qat(sv_q, 2), 314);
        chk("nom_sv_count", sv_q.size(), 3);
        chk("nom_overrun", {24'd0, overrun_cnt}, 32'd0);

        // enable low: the tick in cycle 399 starts nothing and is not an overrun
        enable = 1'b0;
        wait_cyc(420);
        chk("dis_acl_count", acl_q.size(), 3);
        chk("dis_overrun", {24'd0, overrun_cnt}, 32'd0);
        enable = 1'b1;

        // Two NACKs then ACK
        nack_left = 2;
        do_reset();
        wait_cyc(160);
        chk("nack2_mag0", qat(mag_q, 0), 106);
        chk("nack2_mag1", qat(mag_q, 1), 122);
        chk("nack2_mag2", qat(mag_q, 2), 138);
        chk("nack2_mag_count", mag_q.size(), 3);
        chk("nack2_sv0", qat(sv_q, 0), 146);
        chk("nack2_sv_count", sv_q.size(), 1);
        chk("nack2_mag_error", {31'd0, mag_error}, 32'd0);

        // Three NACKs exhaust retries; the next successful read clears the flag
        nack_left = 3;
        do_reset();
        wait_cyc(145);
        chk("nack3_err_before", {31'd0, mag_error}, 32'd0);
        wait_cyc(146);
        chk("nack3_err_set", {31'd0, mag_error}, 32'd1);
        chk("nack3_idle", {31'd0, busy}, 32'd0);
        wait_cyc(213);
        chk("nack3_no_sv", sv_q.size(), 0);
        chk("nack3_err_held", {31'd0, mag_error}, 32'd1);
        wait_cyc(215);
        chk("nack3_err_clr", {31'd0, mag_error}, 32'd0);
        chk("nack3_sv0", qat(sv_q, 0), 214);

        // Accelerometer never answers
        acl_lat = 0;
        do_reset();
`ifdef SCHED_WATCHDOG_EN
        wait_cyc(149);
        chk("acl_tmo_fault_before", {31'd0, acl_fault}, 32'd0);
        chk("acl_tmo_busy_before", {31'd0, busy}, 32'd1);
        wait_cyc(150);
        chk("acl_tmo_fault", {31'd0, acl_fault}, 32'd1);
        chk("acl_tmo_idle", {31'd0, busy}, 32'd0);
        wait_cyc(160);
        acl_lat = 5;
        wait_cyc(205);
        chk("acl_fault_held", {31'd0, acl_fault}, 32'd1);
        wait_cyc(206);
        chk("acl_fault_clr", {31'd0, acl_fault}, 32'd0);
        wait_cyc(220);
        chk("acl_recover_sv", qat(sv_q, 0), 214);
        chk("acl_tmo_overrun", {24'd0, overrun_cnt}, 32'd0);
`else
        wait_cyc(160);
        chk("acl_hold_busy", {31'd0, busy}, 32'd1);
        chk("acl_hold_fault", {31'd0, acl_fault}, 32'd0);
        wait_cyc(400);
        chk("acl_hold_busy_late", {31'd0, busy}, 32'd1);
        chk("acl_hold_overrun", {24'd0, overrun_cnt}, 32'd3);
        chk("acl_hold_no_mag", mag_q.size(), 0);
        acl_lat = 5;
`endif

`ifdef SCHED_WATCHDOG_EN
        // Magnetometer never answers: three watchdog expiries
        mag_lat = 0;
        do_reset();
        wait_cyc(271);
        chk("mag_tmo_err_before", {31'd0, mag_error}, 32'd0);
        wait_cyc(272);
        chk("mag_tmo_err", {31'd0, mag_error}, 32'd1);
        chk("mag_tmo_idle", {31'd0, busy}, 32'd0);
        chk("mag_tmo_mag1", qat(mag_q, 1), 164);
        chk("mag_tmo_mag2", qat(mag_q, 2), 222);
        chk("mag_tmo_no_sv", sv_q.size(), 0);
        chk("mag_tmo_overrun", {24'd0, overrun_cnt}, 32'd1);
        mag_lat = 7;
`else
        // Slow magnetometer: tick 199 dropped
        mag_lat = 150;
        do_reset();
        wait_cyc(199);
        chk("ovr_before", {24'd0, overrun_cnt}, 32'd0);
        wait_cyc(200);
        chk("ovr_one", {24'd0, overrun_cnt}, 32'd1);
        wait_cyc(258);
        chk("ovr_sv0", qat(sv_q, 0), 257);
        chk("ovr_sv_count", sv_q.size(), 1);

        // Magnetometer silent forever: every tick from 199 on is dropped
        mag_lat = 0;
        do_reset();
        wait_cyc(25599);
        chk("sat_254", {24'd0, overrun_cnt}, 32'd254);
        wait_cyc(25600);
        chk("sat_255", {24'd0, overrun_cnt}, 32'd255);
        wait_cyc(25900);
        chk("sat_hold", {24'd0, overrun_cnt}, 32'd255);
        chk("sat_busy", {31'd0, busy}, 32'd1);
        mag_lat = 7;
`endif

        // Reset while in MAG_WAIT; the late mag_done must be ignored
        do_reset();
        wait_cyc(109);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {24'd0, eng.acl_start, eng.mag_start, sample_valid,
                               mag_error, acl_fault, busy, 2'b00}, 32'd0);
        chk("midrst_cyc", cyc, 0);
        reset = 1'b0;
        wait_cyc(20);
        chk("midrst_no_sv", sv_q.size(), 0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        wait_cyc(101);
        chk("midrst_acl0", qat(acl_q, 0), 100);

        chk("start_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
